// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: blank pattern,
// segment bit positions and the active-low hex glyph table.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Bit positions of segments a..g within the 7-bit pattern.
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   // Active-low glyphs for hex digits 0..F.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   // Table lookup of the glyph for the nibble.
   always_comb begin
      pattern = SEG_LUT[nibble];
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode display driver with a double-buffered
// value, per-digit enable/blink/dp, leading-zero suppression and an
// anti-ghosting guard cycle at the end of every digit slot.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pend_flag;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [FRM_W-1:0]        frame_cnt;
   logic                    blink_phase;

   logic                    slot_end;
   logic                    frame_wrap;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic [3:0]              sel_nib;
   logic                    sel_dark;
   logic                    sel_dp;
   logic [6:0]              sel_pat;

   assign slot_end   = (cnt == CNT_LAST);
   assign frame_wrap = slot_end && (idx == IDX_LAST);

   // Leading-zero mask: walk from the most significant digit down, a digit is
   // suppressed while it and everything above it is zero (digit 0 exempt).
   always_comb begin
      logic zero_run;
      lz_dark  = '0;
      zero_run = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         zero_run = zero_run && (shadow[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
         lz_dark[NUM_DIGITS-1-k] = lz_en && zero_run && (k != NUM_DIGITS - 1);
      end
   end

   // Select nibble, darkness and decimal point of the digit currently scanned.
   always_comb begin
      sel_nib  = '0;
      sel_dark = 1'b1;
      sel_dp   = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == idx) begin
            sel_nib  = shadow[4*i +: 4];
            sel_dark = !digit_en[i] || (blink[i] && blink_phase) || lz_dark[i];
            sel_dp   = dp[i];
         end
      end
   end

   hex7_decode u_decode (
      .nibble  (sel_nib),
      .pattern (sel_pat)
   );

   // Prescaler, digit index, frame/blink counter and double buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= '0;
         pending     <= '0;
         pend_flag   <= 1'b0;
         shadow      <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         // A load landing on the wrap edge bypasses the pending buffer so it
         // is shown in the very next frame instead of waiting a whole frame.
         if (frame_wrap) begin
            if (load) begin
               shadow <= value;
            end else if (pend_flag) begin
               shadow <= pending;
            end
            pend_flag <= 1'b0;
            if (frame_cnt == FRM_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= !blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end else if (load) begin
            pending   <= value;
            pend_flag <= 1'b1;
         end
      end
   end

   // Registered pin outputs, blanked on the guard cycle or a dark digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         an         <= '1;
         seg        <= SEG_BLANK;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap;
         if (slot_end || sel_dark) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
         end else begin
            an   <= ~(NUM_DIGITS'(1) << idx);
            seg  <= sel_pat;
            dp_n <= !sel_dp;
         end
      end
   end

endmodule
